// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared op codes, FSM state encoding and nibble width for the
//               calculator core and its iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int NIB_W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_shift_add
// Description : Unsigned W x W -> 2W shift-add multiplier, one multiplier bit
//               per cycle. done is asserted during the final iteration, with
//               p carrying the product that iteration produces.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_shift_add #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic             busy_q,   busy_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [2*W-1:0]   mcand_q,  mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   acc_q,    acc_d;
  logic [2*W-1:0]   acc_step;

  // Load operands on start, then add the shifted multiplicand for each set bit.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (!busy_q) begin
      if (start) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        mcand_d  = {{W{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
      end
    end else begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // Iteration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);
  assign p    = acc_step;

endmodule
`default_nettype wire

// File: rtl/calc_core_p.sv
`default_nettype none
// ============================================================================
// Module      : calc_core_p
// Description : Calculator core: nibble-editable operands A/B, single-cycle
//               ALU/shift ops, iterative multiply, result history and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_core_p
  import calc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W/4-1:0]   inc_lvl,
  input  logic             dec,
  input  logic [1:0]       sel,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [2*W-1:0]   result,
  output logic [2*W-1:0]   last_result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int NIB = W / NIB_W;

  logic [1:0]     rst_sync_q, rst_sync_d;
  logic           rst_core_n;
  state_e         state_q,  state_d;
  logic [NIB-1:0] prev_q,   prev_d;
  logic [W-1:0]   a_q,      a_d;
  logic [W-1:0]   b_q,      b_d;
  logic [2*W-1:0] result_q, result_d;
  logic [2*W-1:0] last_q,   last_d;
  logic           zero_q,   zero_d;
  logic           carry_q,  carry_d;
  logic           ovf_q,    ovf_d;
  logic           err_q,    err_d;
  logic           done_q,   done_d;

  logic           mul_start, mul_busy, mul_done;
  logic [2*W-1:0] mul_p;
  logic [NIB-1:0] rise;
  logic [3:0]     step;
  logic           locked;
  logic [W:0]     sum_w, diff_w;
  logic [W-1:0]   alu_res;
  logic           alu_carry, alu_ovf, alu_err;

  // Reset asserts immediately but releases only on a clock edge.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  // Two-stage reset release synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_core_n = rst_sync_q[1];

  mul_shift_add #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_core_n),
    .start (mul_start),
    .a     (a_q),
    .b     (b_q),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Single-cycle datapath; shifts work on the low half of the current result.
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    diff_w    = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_w[W-1:0];
        alu_carry = sum_w[W];
        alu_ovf   = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        alu_res   = diff_w[W-1:0];
        alu_carry = diff_w[W];
        alu_ovf   = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
      end
      OP_MUL:  alu_res = '0;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_NOT:  alu_res = ~a_q;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (a_q < b_q)};
      OP_SLL:  alu_res = {result_q[W-2:0], 1'b0};
      OP_SRL:  alu_res = {1'b0, result_q[W-1:1]};
      OP_SRA:  alu_res = {result_q[W-1], result_q[W-1:1]};
      OP_ROR:  alu_res = {result_q[0], result_q[W-1:1]};
      default: alu_err = 1'b1;
    endcase
  end

  // Either view of an active multiply locks the operands.
  assign locked = (state_q == ST_MUL) | mul_busy;

  // Next state: button edits, op dispatch, result/flag capture.
  always_comb begin
    state_d   = state_q;
    prev_d    = inc_lvl;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    last_d    = last_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    rise      = inc_lvl & ~prev_q;
    step      = dec ? 4'hF : 4'h1;

    // Nibbles wrap independently; no carry between them.
    if (!locked && !sel[1]) begin
      for (int i = 0; i < NIB; i++) begin
        if (rise[i]) begin
          if (!sel[0]) a_d[i*NIB_W +: NIB_W] = a_q[i*NIB_W +: NIB_W] + step;
          else         b_d[i*NIB_W +: NIB_W] = b_q[i*NIB_W +: NIB_W] + step;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            last_d   = result_q;
            result_d = {{W{1'b0}}, alu_res};
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            err_d    = alu_err;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          last_d   = result_q;
          result_d = mul_p;
          zero_d   = (mul_p == '0);
          carry_d  = 1'b0;
          ovf_d    = |mul_p[2*W-1:W];
          err_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core state register.
  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      last_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      last_q   <= last_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy        = locked;
  assign done        = done_q;
  assign a           = a_q;
  assign b           = b_q;
  assign result      = result_q;
  assign last_result = last_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign ovf         = ovf_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_core_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core_p
// Description : Directed, table-driven bench for calc_core_p (W = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_core_p;

  logic        clk;
  logic        rst_n;
  logic [7:0]  inc_lvl;
  logic        dec;
  logic [1:0]  sel;
  logic [3:0]  op;
  logic        start;
  logic        busy, done, zero, carry, ovf, err;
  logic [31:0] a, b;
  logic [63:0] result, last_result;

  calc_core_p #(.W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_lvl     (inc_lvl),
    .dec         (dec),
    .sel         (sel),
    .op          (op),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .a           (a),
    .b           (b),
    .result      (result),
    .last_result (last_result),
    .zero        (zero),
    .carry       (carry),
    .ovf         (ovf),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [3:0]  vop;
    logic [63:0] res;
    logic        z;
    logic        c;
    logic        o;
    logic        e;
  } vec_t;

  vec_t        vt [22];
  int          total;
  int          passes;
  logic [31:0] ma, mb;
  logic [63:0] prev_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] m);
    inc_lvl = m;
    tick();
    inc_lvl = 8'h00;
    tick();
  endtask

  // Walk each nibble of the chosen operand up to its target by increments.
  task automatic load(input logic sel_b, input logic [31:0] tgt);
    logic [31:0] cur;
    logic [3:0]  d [8];
    logic [7:0]  m;
    cur = sel_b ? mb : ma;
    sel = {1'b0, sel_b};
    dec = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = tgt[i*4 +: 4] - cur[i*4 +: 4];
    for (int k = 1; k < 16; k++) begin
      m = '0;
      for (int i = 0; i < 8; i++) m[i] = (int'(d[i]) >= k);
      if (m != 8'h00) pulse(m);
    end
    if (sel_b) mb = tgt;
    else       ma = tgt;
    sel = 2'b10;
  endtask

  initial begin
    int done_cyc;
    int busy_bad;
    total = 0; passes = 0;
    rst_n = 1'b0; inc_lvl = '0; dec = 1'b0; sel = 2'b10; op = '0; start = 1'b0;
    ma = '0; mb = '0; prev_res = '0;

    //               a             b             op     result                z     c     o     e
    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  64'h0,                1'b1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{32'h0000_0003, 32'h0000_0005, 4'd1,  64'h0000_0000_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{32'h0000_0003, 32'h0000_0005, 4'd8,  64'h1,                1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{32'h0000_0003, 32'h0000_0005, 4'd7,  64'h1,                1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd7,  64'h1,                1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd8,  64'h0,                1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 4'd3,  64'h0000_0000_00F0_1200, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 4'd4,  64'h0000_0000_FFF0_FF34, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 4'd5,  64'h0000_0000_000F_00CB, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'hF0F0_1234, 32'h0FF0_FF00, 4'd6,  64'h0000_0000_0F0F_EDCB, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{32'h8000_0000, 32'h0000_0001, 4'd1,  64'h0000_0000_7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{32'h8000_0000, 32'h0000_0001, 4'd0,  64'h0000_0000_8000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{32'h8000_0000, 32'h0000_0001, 4'd11, 64'h0000_0000_C000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{32'h8000_0000, 32'h0000_0001, 4'd12, 64'h0000_0000_6000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{32'h8000_0000, 32'h0000_0001, 4'd9,  64'h0000_0000_C000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{32'h8000_0000, 32'h0000_0001, 4'd10, 64'h0000_0000_6000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[17] = '{32'h8000_0000, 32'h0000_0001, 4'd12, 64'h0000_0000_3000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{32'h8000_0000, 32'h0000_0001, 4'd14, 64'h0,                1'b1, 1'b0, 1'b0, 1'b1};
    vt[19] = '{32'h8000_0000, 32'h0000_0001, 4'd0,  64'h0000_0000_8000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{32'h8000_0000, 32'h0000_0001, 4'd12, 64'h0000_0000_C000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{32'h8000_0000, 32'h0000_0001, 4'd13, 64'h0,                1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("rst_a", a, 64'h0);
    chk("rst_b", b, 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_flags", {busy, done, zero, carry, ovf, err}, 64'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Nibble edits: a held level counts once
    sel = 2'b00; dec = 1'b0;
    inc_lvl = 8'h01;
    repeat (5) tick();
    inc_lvl = 8'h00;
    tick();
    chk("hold_once", a, 64'h1);
    pulse(8'h81);
    pulse(8'h01);
    chk("edit_a", a, 64'h1000_0003);
    ma = 32'h1000_0003;
    sel = 2'b01; dec = 1'b1;
    pulse(8'h01);
    chk("dec_wrap_b", b, 64'h0000_000F);
    dec = 1'b0;
    pulse(8'h01);
    chk("inc_wrap_b", b, 64'h0);
    sel = 2'b10;
    pulse(8'hFF);
    chk("sel_none", {a, b}, {32'h1000_0003, 32'h0});

    // Table of single-cycle ops
    for (int i = 0; i < 22; i++) begin
      load(1'b0, vt[i].va);
      load(1'b1, vt[i].vb);
      chk($sformatf("v%0d_ops", i), {a, b}, {vt[i].va, vt[i].vb});
      op = vt[i].vop;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_done", i), {busy, done}, 64'h1);
      chk($sformatf("v%0d_result", i), result, vt[i].res);
      chk($sformatf("v%0d_last", i), last_result, prev_res);
      chk($sformatf("v%0d_flags", i), {zero, carry, ovf, err},
          {vt[i].z, vt[i].c, vt[i].o, vt[i].e});
      prev_res = vt[i].res;
      tick();
      chk($sformatf("v%0d_done_pulse", i), done, 64'h0);
    end

    // Multiply: busy 32 cycles, done on cycle 33, edits and start ignored
    load(1'b0, 32'hFFFF_FFFF);
    load(1'b1, 32'h0000_0002);
    sel = 2'b00;
    op = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = 0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!busy) busy_bad++;
      if (c == 5) inc_lvl = 8'hFF;
      if (c == 6) inc_lvl = 8'h00;
      if (c == 10) begin start = 1'b1; op = 4'd0; end
      if (c == 11) start = 1'b0;
      tick();
    end
    chk("mul_latency", done_cyc, 64'd33);
    chk("mul_busy_cycles", busy_bad, 64'd0);
    chk("mul_busy_drop", busy, 64'h0);
    chk("mul_result", result, 64'h1_FFFF_FFFE);
    chk("mul_last", last_result, prev_res);
    chk("mul_flags", {zero, carry, ovf, err}, 64'b0010);
    chk("mul_ops_frozen", {a, b}, {32'hFFFF_FFFF, 32'h2});
    tick();
    chk("mul_after", {busy, done}, 64'h0);
    chk("mul_no_repeat", result, 64'h1_FFFF_FFFE);

    // Reset in the middle of a multiply aborts everything
    op = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort_busy", busy, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_result", {result, last_result}, 128'h0);
    chk("abort_ops", {a, b}, 64'h0);
    chk("abort_flags", {busy, done, zero, carry, ovf, err}, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_idle", {busy, done, result}, 66'h0);
    ma = '0; mb = '0;
    load(1'b0, 32'h5);
    load(1'b1, 32'h7);
    op = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_add", {done, result}, {1'b1, 64'hC});
    chk("post_rst_last", last_result, 64'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_core_p.md
Name: calc_core_p

Overview:
Parametrised, fully synchronous calculator core for the board-level calculator top.
- Holds two W-bit operands edited nibble-by-nibble from debounced push-buttons.
- Executes a selected ALU/shift/multiply operation on a start strobe.
- Registers result, previous result and flags for the 7-segment display drivers.
- Replaces the button-clocked operand registers and latch-based result mux with single-clock logic, a proper handshake, and an iterative multiplier.

Parameters:
W, 32, operand width in bits; must be a multiple of 4, minimum 8.
NIB, W/4, number of editable nibbles per operand; derived, not overridable.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inc_lvl  in  NIB  debounced button levels, one per nibble; the core edge-detects them
dec  in  1  1 = a button edge decrements its nibble, 0 = increments it
sel  in  2  edit target: 00 = A, 01 = B, 1x = no edit
op  in  4  operation code, sampled on start
start  in  1  one-cycle operation request
busy  out  1  operation in progress
done  out  1  one-cycle pulse when result is updated
a  out  W  operand A
b  out  W  operand B
result  out  2W  current result
last_result  out  2W  result before the most recent update
zero  out  1  result == 0
carry  out  1  carry/borrow flag
ovf  out  1  overflow flag
err  out  1  last op code was reserved

Behaviour:
- Reset (async, rst_n=0): every output and every internal register is 0, including edge-detect history and FSM state (IDLE). Deassertion must be synchronous to clk.
- Edge detect: prev <= inc_lvl every cycle. Rise on bit i = inc_lvl[i] & ~prev[i].
- Nibble edit:
  - On a rise at bit i, nibble i of the sel target is updated by +1 (dec=0) or -1 (dec=1) mod 16. No carry or borrow into neighbouring nibbles.
  - Multiple simultaneous rises all apply in the same cycle. sel=1x: no change.
  - Edits are ignored while busy=1; operands stay frozen.
- Op codes:
  - 0 add, 1 sub (A-B), 2 mul (unsigned, 2W result), 3 and, 4 or, 5 nor, 6 not A.
  - 7 slt (signed, result 1/0), 8 sltu (unsigned, result 1/0).
  - 9 logical left shift by 1, 10 logical right shift by 1, 11 arithmetic right shift by 1, 12 rotate right by 1. Shifts and rotate act on result[W-1:0], so operations chain.
  - 13-15 reserved: result = 0, err = 1. err is cleared by any valid op.
- Width rule: every non-mul op writes result[2W-1:W] = 0.
- FSM states: IDLE, MUL.
  - IDLE, start=1, op!=2: result, flags and last_result update at the next edge. done=1 that cycle; busy never asserts.
  - IDLE, start=1, op=2: go to MUL, busy=1 from the next cycle. Shift-add runs W iterations. At the W-th edge, result is written, done pulses, busy drops, state returns to IDLE. Latency from start to done = W+1 cycles.
  - start while busy=1: ignored. start with an unchanged op repeats the op.
- On every result update, last_result <= old result.
- Flags (updated with result):
  - zero = (new result == 0).
  - carry: add = carry-out; sub = borrow (A <u B); all others 0.
  - ovf: add/sub = signed overflow; mul = (result[2W-1:W] != 0); others 0.
- Reset during MUL aborts: result is not written and all registers return to 0.

Decomposition:
- Package calc_pkg holds: op-code localparams (OP_ADD .. OP_ROR), FSM state encoding, and the nibble-width constant 4.
- One sub-module, mul_shift_add, parametrised by W:
  - Interface: clk, rst_n, start, a, b, busy, done, p[2W-1:0].
  - Iterative, one bit per cycle.
  - calc_core_p instantiates it; the add/sub/logic/shift datapath stays inline.

Test Plan:
- Reset, then sel=00, dec=0, three rising edges on inc_lvl[0] and one on inc_lvl[7] -> a=32'h1000_0003. Holding a level high for 5 cycles counts once.
- a=FFFF_FFFF, b=1, op=0, start -> next cycle done=1, result=0, zero=1, carry=1, ovf=0.
- a=3, b=5, op=1 -> result[31:0]=FFFF_FFFE, carry=1. Then op=8 (sltu) -> result=1 and last_result[31:0]=FFFF_FFFE.
- a=FFFF_FFFF, b=2, op=2 -> busy high for 32 cycles, done at cycle 33, result=64'h1_FFFF_FFFE, ovf=1. Button edges and a second start during busy change nothing.
- result=8000_0001, then op=11 -> C000_0000; then op=12 -> 6000_0000; then op=14 -> result=0, err=1.
- rst_n=0 at cycle 10 of a multiply -> all outputs 0 immediately. After release, a fresh add completes normally.
